stream_demux: RTL and testbench
===============================

Name: stream_demux

Overview:
- Registered 1:2 (S == 1) or 1:4 (S == 2) stream demultiplexer. It is the distribution-side counterpart of the 2:1/4:1 select mux.
- One input stream with valid/ready and a per-word select is routed to one of four output ports (a, b, c, d), each with its own valid/ready.
- A one-entry holding register decouples input from outputs and gives 1-cycle latency with full throughput.
- An elaboration-time check rejects illegal configurations.

Parameters:
- N, 8, data width in bits; must be >= 1.
- S, 1 (package default MUX_CONFIG), select width. 1 gives ports a/b; 2 gives ports a/b/c/d. Any other value is fatal at elaboration.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset, asynchronous, active-high
- i_data  input  N  input data word
- i_sel  input  S  destination select, sampled with i_data
- i_valid  input  1  input word valid
- o_ready  output  1  block can accept input this cycle
- o_y_a, o_y_b, o_y_c, o_y_d  output  N each  output data per port
- o_valid_a, o_valid_b, o_valid_c, o_valid_d  output  1 each  output valid per port
- i_ready_a, i_ready_b, i_ready_c, i_ready_d  input  1 each  downstream ready per port

Behaviour:
- Elaboration: generate-time check. $fatal if !(S inside {[1:2]}) or N < 1; the message includes %m and the offending value.
- Select decode, zero-extended to 2 bits:
  - 00 -> a, 01 -> b, 10 -> c, 11 -> d.
  - With S == 1 only a/b are reachable.
  - With S == 1, o_valid_c/d and o_y_c/d are tied 0 and i_ready_c/d are ignored.
- FSM with two states, EMPTY and FULL. The holding register stores {data, dest}.
  - EMPTY: o_ready = 1. On i_valid, capture into the register and go to FULL.
  - FULL: o_valid_<dest> = 1, all other o_valid_* = 0, and o_y_<dest> = held data.
    - On i_ready_<dest> with i_valid: reload the register (pass-through) and stay FULL.
    - On i_ready_<dest> with !i_valid: go to EMPTY.
    - Without i_ready_<dest>: hold. Data and dest stay stable while valid is high.
  - o_ready = (state == EMPTY) || i_ready_<dest>. This is a combinational path from downstream ready.
- Latency: a word accepted at cycle t is presented at t+1. Sustained throughput is 1 word/cycle when the destination is always ready.
- Non-selected o_y_* are driven 0, never stale data.
- Reset (any time, including mid-transfer):
  - State goes to EMPTY and the held word is discarded.
  - All o_valid_* = 0 and all o_y_* = 0.
  - o_ready = 1 from the first cycle after i_rst deasserts.
- Destination switch back-to-back (a then b): no bubble. Each word goes only to its own port.
- Ready on a non-selected port has no effect.
- Protocol rule: the upstream must not change i_data or i_sel while i_valid && !o_ready.

Optional Feature:
- Macro: STREAM_DEMUX_CNT_EN.
- When defined:
  - Adds outputs o_cnt_a..o_cnt_d, 16 bits each.
  - Each counts completed transfers (o_valid_x && i_ready_x) on its port.
  - Counters saturate at 16'hFFFF, reset to 0 on i_rst, and clear synchronously on the added input i_cnt_clr.
  - If clear and a transfer occur in the same cycle, clear wins.
- When undefined: no counters and no i_cnt_clr/o_cnt_* ports. Datapath behaviour is identical.

Decomposition:
- Package stream_demux_pkg holds:
  - MUX_CONFIG = 1
  - Port-select localparams SEL_A/B/C/D = 2'b00..2'b11
  - State typedef enum logic {EMPTY, FULL}
  - CNT_W = 16
- One natural sub-module, stream_demux_sat_cnt: a 16-bit saturating counter with clear. It is instantiated four times only under STREAM_DEMUX_CNT_EN.

Test Plan:
- Reset mid-transfer: S=2, hold 8'h5A to port c with i_ready_c=0, then pulse i_rst. All o_valid_* = 0, o_y_* = 0, o_ready = 1 after release, and 8'h5A is never delivered.
- Streaming: S=2, all readies 1, send 8'h11/8'h22/8'h33/8'h44 with sel 0,1,2,3 on consecutive cycles. Each appears on a,b,c,d one cycle later, with no bubbles and o_ready constantly 1.
- Backpressure: S=1, send 8'hA5 to b with i_ready_b=0 for 3 cycles. o_valid_b and o_y_b=8'hA5 are held stable, o_ready=0, and i_ready_a=1 has no effect. Raise i_ready_b: transfer completes and o_ready=1 in that cycle.
- S=1 tie-offs: drive i_ready_c=i_ready_d=1 with traffic to a/b. o_valid_c/d and o_y_c/d stay 0 throughout.
- Illegal config: elaborate with S=3 -> $fatal with a message containing "S=3". Likewise S=0.
- Counters (STREAM_DEMUX_CNT_EN):
  - 65540 transfers to port a -> o_cnt_a = 16'hFFFF and others 0.
  - i_cnt_clr asserted in the same cycle as a transfer -> o_cnt_a = 0 next cycle.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared configuration, select encodings and FSM state type for stream_demux.
package stream_demux_pkg;

    localparam int MUX_CONFIG = 1;
    localparam int CNT_W      = 16;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    typedef enum logic {EMPTY, FULL} state_t;

endpackage

// File: rtl/stream_demux_sat_cnt.sv
// Saturating transfer counter with synchronous clear; clear has priority over increment.
module stream_demux_sat_cnt
    import stream_demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Registered 1:2 / 1:4 stream demultiplexer with a one-entry holding register.
// Optional per-port transfer counters are enabled by defining STREAM_DEMUX_CNT_EN.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int N = 8,
    parameter int S = MUX_CONFIG
) (
    input  logic             i_clk,
    input  logic             i_rst,
`ifdef STREAM_DEMUX_CNT_EN
    input  logic             i_cnt_clr,
    output logic [CNT_W-1:0] o_cnt_a,
    output logic [CNT_W-1:0] o_cnt_b,
    output logic [CNT_W-1:0] o_cnt_c,
    output logic [CNT_W-1:0] o_cnt_d,
`endif
    input  logic [N-1:0]     i_data,
    input  logic [S-1:0]     i_sel,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [N-1:0]     o_y_a,
    output logic [N-1:0]     o_y_b,
    output logic [N-1:0]     o_y_c,
    output logic [N-1:0]     o_y_d,
    output logic             o_valid_a,
    output logic             o_valid_b,
    output logic             o_valid_c,
    output logic             o_valid_d,
    input  logic             i_ready_a,
    input  logic             i_ready_b,
    input  logic             i_ready_c,
    input  logic             i_ready_d
);

    generate
        if (!(S inside {[1:2]}) || (N < 1)) begin : g_bad_config
            $fatal(1, "%m: illegal configuration S=%0d N=%0d", S, N);
        end
    endgenerate

    // Ports c/d do not exist in the 1:2 configuration.
    localparam logic [3:0] PORT_MASK = (S == 1) ? 4'b0011 : 4'b1111;

    state_t       state;
    state_t       next_state;
    logic [N-1:0] held_data;
    logic [1:0]   held_dest;
    logic [1:0]   sel_ext;
    logic [3:0]   ready_vec;
    logic [3:0]   valid_vec;
    logic         dest_ready;
    logic         load;

    assign sel_ext    = 2'(i_sel);
    assign ready_vec  = {i_ready_d, i_ready_c, i_ready_b, i_ready_a} & PORT_MASK;
    assign dest_ready = ready_vec[held_dest];

    always_comb begin
        next_state = state;
        load       = 1'b0;
        o_ready    = 1'b0;
        case (state)
            EMPTY: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    load       = 1'b1;
                    next_state = FULL;
                end
            end
            FULL: begin
                o_ready = dest_ready;
                if (dest_ready) begin
                    if (i_valid) begin
                        load = 1'b1;
                    end else begin
                        next_state = EMPTY;
                    end
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= EMPTY;
            held_data <= '0;
            held_dest <= SEL_A;
        end else begin
            state <= next_state;
            if (load) begin
                held_data <= i_data;
                held_dest <= sel_ext;
            end
        end
    end

    always_comb begin
        valid_vec = '0;
        if (state == FULL) begin
            case (held_dest)
                SEL_A:   valid_vec[0] = 1'b1;
                SEL_B:   valid_vec[1] = 1'b1;
                SEL_C:   valid_vec[2] = 1'b1;
                SEL_D:   valid_vec[3] = 1'b1;
                default: valid_vec    = '0;
            endcase
        end
        valid_vec = valid_vec & PORT_MASK;
    end

    assign o_valid_a = valid_vec[0];
    assign o_valid_b = valid_vec[1];
    assign o_valid_c = valid_vec[2];
    assign o_valid_d = valid_vec[3];

    // Idle ports are forced to zero so stale data never leaks out.
    assign o_y_a = valid_vec[0] ? held_data : '0;
    assign o_y_b = valid_vec[1] ? held_data : '0;
    assign o_y_c = valid_vec[2] ? held_data : '0;
    assign o_y_d = valid_vec[3] ? held_data : '0;

`ifdef STREAM_DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt [4];

    for (genvar p = 0; p < 4; p++) begin : g_cnt
        stream_demux_sat_cnt u_cnt (
            .clk   (i_clk),
            .rst   (i_rst),
            .clr   (i_cnt_clr),
            .inc   (valid_vec[p] & ready_vec[p]),
            .count (cnt[p])
        );
    end

    assign o_cnt_a = cnt[0];
    assign o_cnt_b = cnt[1];
    assign o_cnt_c = cnt[2];
    assign o_cnt_d = cnt[3];
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: S=2 and S=1 instances, table vectors plus corner sequences.
// Counter checks are compiled in when STREAM_DEMUX_CNT_EN is defined.
module tb_stream_demux;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // S=2 instance signals
    logic [7:0] d2_data;
    logic [1:0] d2_sel;
    logic       d2_valid, d2_ordy;
    logic [3:0] d2_rdy;
    logic [7:0] d2_ya, d2_yb, d2_yc, d2_yd;
    logic       d2_va, d2_vb, d2_vc, d2_vd;

    // S=1 instance signals
    logic [7:0] d1_data;
    logic [0:0] d1_sel;
    logic       d1_valid, d1_ordy;
    logic [3:0] d1_rdy;
    logic [7:0] d1_ya, d1_yb, d1_yc, d1_yd;
    logic       d1_va, d1_vb, d1_vc, d1_vd;

`ifdef STREAM_DEMUX_CNT_EN
    logic        cnt_clr;
    logic [15:0] c2_a, c2_b, c2_c, c2_d;
    logic [15:0] c1_a, c1_b, c1_c, c1_d;
`endif

    stream_demux #(.N(8), .S(2)) u_dut2 (
        .i_clk     (clk),
        .i_rst     (rst),
`ifdef STREAM_DEMUX_CNT_EN
        .i_cnt_clr (cnt_clr),
        .o_cnt_a   (c2_a),
        .o_cnt_b   (c2_b),
        .o_cnt_c   (c2_c),
        .o_cnt_d   (c2_d),
`endif
        .i_data    (d2_data),
        .i_sel     (d2_sel),
        .i_valid   (d2_valid),
        .o_ready   (d2_ordy),
        .o_y_a     (d2_ya),
        .o_y_b     (d2_yb),
        .o_y_c     (d2_yc),
        .o_y_d     (d2_yd),
        .o_valid_a (d2_va),
        .o_valid_b (d2_vb),
        .o_valid_c (d2_vc),
        .o_valid_d (d2_vd),
        .i_ready_a (d2_rdy[0]),
        .i_ready_b (d2_rdy[1]),
        .i_ready_c (d2_rdy[2]),
        .i_ready_d (d2_rdy[3])
    );

    stream_demux #(.N(8), .S(1)) u_dut1 (
        .i_clk     (clk),
        .i_rst     (rst),
`ifdef STREAM_DEMUX_CNT_EN
        .i_cnt_clr (cnt_clr),
        .o_cnt_a   (c1_a),
        .o_cnt_b   (c1_b),
        .o_cnt_c   (c1_c),
        .o_cnt_d   (c1_d),
`endif
        .i_data    (d1_data),
        .i_sel     (d1_sel),
        .i_valid   (d1_valid),
        .o_ready   (d1_ordy),
        .o_y_a     (d1_ya),
        .o_y_b     (d1_yb),
        .o_y_c     (d1_yc),
        .o_y_d     (d1_yd),
        .o_valid_a (d1_va),
        .o_valid_b (d1_vb),
        .o_valid_c (d1_vc),
        .o_valid_d (d1_vd),
        .i_ready_a (d1_rdy[0]),
        .i_ready_b (d1_rdy[1]),
        .i_ready_c (d1_rdy[2]),
        .i_ready_d (d1_rdy[3])
    );

    typedef struct {
        logic [7:0] data;
        logic [1:0] sel;
        logic       valid;
        logic [3:0] rdy;
        logic       exp_rdy;
        logic [3:0] exp_vld;
        logic [7:0] exp_dat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] exp_ys(input logic [3:0] vld, input logic [7:0] dat);
        logic [31:0] r;
        r = '0;
        for (int p = 0; p < 4; p++) begin
            if (vld[p]) r[p*8 +: 8] = dat;
        end
        return r;
    endfunction

    task automatic chk2(input string name, input logic rdy, input logic [3:0] vld, input logic [7:0] dat);
        chk({name, ".ready"}, 64'(d2_ordy), 64'(rdy));
        chk({name, ".valid"}, 64'({d2_vd, d2_vc, d2_vb, d2_va}), 64'(vld));
        chk({name, ".y"}, 64'({d2_yd, d2_yc, d2_yb, d2_ya}), 64'(exp_ys(vld, dat)));
    endtask

    task automatic chk1(input string name, input logic rdy, input logic [3:0] vld, input logic [7:0] dat);
        chk({name, ".ready"}, 64'(d1_ordy), 64'(rdy));
        chk({name, ".valid"}, 64'({d1_vd, d1_vc, d1_vb, d1_va}), 64'(vld));
        chk({name, ".y"}, 64'({d1_yd, d1_yc, d1_yb, d1_ya}), 64'(exp_ys(vld, dat)));
    endtask

    vec_t vecs[13];

    initial begin
        // streaming a,b,c,d back-to-back, then drain
        vecs[0]  = '{8'h11, 2'd0, 1'b1, 4'b1111, 1'b1, 4'b0000, 8'h00};
        vecs[1]  = '{8'h22, 2'd1, 1'b1, 4'b1111, 1'b1, 4'b0001, 8'h11};
        vecs[2]  = '{8'h33, 2'd2, 1'b1, 4'b1111, 1'b1, 4'b0010, 8'h22};
        vecs[3]  = '{8'h44, 2'd3, 1'b1, 4'b1111, 1'b1, 4'b0100, 8'h33};
        vecs[4]  = '{8'h00, 2'd0, 1'b0, 4'b1111, 1'b1, 4'b1000, 8'h44};
        vecs[5]  = '{8'h00, 2'd0, 1'b0, 4'b1111, 1'b1, 4'b0000, 8'h00};
        // port c stalled while other readies are high, then reload to d, stall d, drain
        vecs[6]  = '{8'h77, 2'd2, 1'b1, 4'b0000, 1'b1, 4'b0000, 8'h00};
        vecs[7]  = '{8'h77, 2'd2, 1'b1, 4'b1011, 1'b0, 4'b0100, 8'h77};
        vecs[8]  = '{8'h77, 2'd2, 1'b1, 4'b1011, 1'b0, 4'b0100, 8'h77};
        vecs[9]  = '{8'h88, 2'd3, 1'b1, 4'b0100, 1'b1, 4'b0100, 8'h77};
        vecs[10] = '{8'h00, 2'd0, 1'b0, 4'b0111, 1'b0, 4'b1000, 8'h88};
        vecs[11] = '{8'h00, 2'd0, 1'b0, 4'b1000, 1'b1, 4'b1000, 8'h88};
        vecs[12] = '{8'h00, 2'd0, 1'b0, 4'b1111, 1'b1, 4'b0000, 8'h00};

        rst = 1'b1;
        d2_data = '0; d2_sel = '0; d2_valid = 1'b0; d2_rdy = '0;
        d1_data = '0; d1_sel = '0; d1_valid = 1'b0; d1_rdy = '0;
`ifdef STREAM_DEMUX_CNT_EN
        cnt_clr = 1'b0;
`endif
        @(posedge clk);
        @(negedge clk);
        chk2("in_reset2", 1'b1, 4'b0000, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk2("reset2", 1'b1, 4'b0000, 8'h00);
        chk1("reset1", 1'b1, 4'b0000, 8'h00);
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            d2_data  = vecs[i].data;
            d2_sel   = vecs[i].sel;
            d2_valid = vecs[i].valid;
            d2_rdy   = vecs[i].rdy;
            @(negedge clk);
            chk2($sformatf("vec%0d", i), vecs[i].exp_rdy, vecs[i].exp_vld, vecs[i].exp_dat);
            @(posedge clk);
            #1;
        end

        // S=1 backpressure on b; ready on a and on nonexistent c/d must not matter
        d1_data = 8'hA5; d1_sel = 1'b1; d1_valid = 1'b1; d1_rdy = 4'b1101;
        @(negedge clk);
        chk1("bp_accept", 1'b1, 4'b0000, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk1($sformatf("bp_hold%0d", i), 1'b0, 4'b0010, 8'hA5);
        end
        @(posedge clk);
        #1 d1_rdy = 4'b1111; d1_valid = 1'b0;
        @(negedge clk);
        chk1("bp_release", 1'b1, 4'b0010, 8'hA5);
        @(posedge clk);
        #1 d1_data = 8'h3C; d1_sel = 1'b0; d1_valid = 1'b1;
        @(negedge clk);
        chk1("bp_drained", 1'b1, 4'b0000, 8'h00);
        @(posedge clk);
        #1 d1_valid = 1'b0;
        @(negedge clk);
        chk1("s1_port_a", 1'b1, 4'b0001, 8'h3C);
        @(posedge clk);
        #1;

        // reset mid-transfer with a stalled word on port c
        d2_data = 8'h5A; d2_sel = 2'd2; d2_valid = 1'b1; d2_rdy = 4'b0000;
        @(posedge clk);
        #1 d2_valid = 1'b0;
        @(negedge clk);
        chk2("rst_pre", 1'b0, 4'b0100, 8'h5A);
        #1 rst = 1'b1;
        #1;
        chk2("rst_async", 1'b1, 4'b0000, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0; d2_rdy = 4'b1111;
        @(negedge clk);
        chk2("rst_post0", 1'b1, 4'b0000, 8'h00);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk2("rst_post1", 1'b1, 4'b0000, 8'h00);

`ifdef STREAM_DEMUX_CNT_EN
        chk("cnt_rst_c", 64'(c2_c), 64'h0);
        @(posedge clk);
        #1 d2_data = 8'h01; d2_sel = 2'd0; d2_valid = 1'b1; d2_rdy = 4'b1111;
        // 65541 accepts yield 65540 completed transfers before the last edge sampled
        for (int i = 0; i < 65541; i++) begin
            @(posedge clk);
        end
        #1;
        @(negedge clk);
        chk("cnt_sat_a", 64'(c2_a), 64'hFFFF);
        chk("cnt_sat_bcd", 64'({c2_b, c2_c, c2_d}), 64'h0);
        chk("cnt_s1_c", 64'({c1_c, c1_d}), 64'h0);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        @(negedge clk);
        chk("cnt_clr_wins", 64'(c2_a), 64'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("cnt_after_clr", 64'(c2_a), 64'h1);
        d2_valid = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
